// File: rtl/mul_seq_pkg.sv
// Shared constants for the sequential multiplier: operand width, iteration counter width
// and the FSM state codes. State codes stay the same whether or not MUL_SIGNED_EN is
// defined, so waveforms from the signed and unsigned builds line up.
package mul_seq_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [CNT_W-1:0] CNT_LAST = '1;   // 32nd CALC iteration

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_NEG_IN_A   = 3'd1;
    localparam state_t ST_NEG_IN_B   = 3'd2;
    localparam state_t ST_CALC       = 3'd3;
    localparam state_t ST_NEG_OUT_LO = 3'd4;
    localparam state_t ST_NEG_OUT_HI = 3'd5;
    localparam state_t ST_DONE       = 3'd6;

endpackage

// File: rtl/mul_seq_adder32.sv
// Adder32: 32-bit carry-lookahead adder, eight 4-bit lookahead groups chained by group carry.
// Latency: combinational. Backpressure: none.
// Ports: A, B operands; Cin carry in; F sum; Cout carry out.
module Adder32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] F,
    output logic        Cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    assign g = A & B;
    assign p = A ^ B;

    always_comb begin
        c    = '0;
        c[0] = Cin;
        for (int k = 0; k < 8; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
        end
    end

    assign F    = p ^ c[31:0];
    assign Cout = c[32];

endmodule

// File: rtl/mul_seq.sv
// mul_seq: 32x32 shift-and-add multiplier, one multiplier bit per cycle through a shared Adder32.
// Latency: done 33 edges after accept (37 with MUL_SIGNED_EN, which adds the four NEG states).
// Backpressure: start is sampled only in IDLE; a start while busy is dropped, never queued.
// Ports: clk/rst (async, active-high); start, a, b, sgn request; busy, done, prod, zf status.
import mul_seq_pkg::*;

module mul_seq (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic              sgn,
    output logic              busy,
    output logic              done,
    output logic [2*XLEN-1:0] prod,
    output logic              zf
);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   m_q, m_d;
    logic [XLEN-1:0]   phi_q, phi_d;
    logic [XLEN-1:0]   plo_q, plo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] prod_q;
    logic              zf_q;
    logic              done_q;

    logic [XLEN-1:0]   add_a, add_b, add_f;
    logic              add_cin, add_co;

`ifdef MUL_SIGNED_EN
    logic sgn_q, sgn_d;
    logic neg_q, neg_d;
    logic cy_q, cy_d;     // carry out of the low-word negation, feeds the high word
`else
    logic unused_sgn;
    assign unused_sgn = sgn;
`endif

    Adder32 u_add (
        .A    (add_a),
        .B    (add_b),
        .Cin  (add_cin),
        .F    (add_f),
        .Cout (add_co)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        cnt_d   = cnt_q;
        add_a   = phi_q;
        add_b   = m_q;
        add_cin = 1'b0;
`ifdef MUL_SIGNED_EN
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        cy_d    = cy_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d   = a;
                    plo_d = b;
                    phi_d = '0;
                    cnt_d = '0;
`ifdef MUL_SIGNED_EN
                    sgn_d   = sgn;
                    neg_d   = sgn & (a[XLEN-1] ^ b[XLEN-1]);
                    state_d = ST_NEG_IN_A;
`else
                    state_d = ST_CALC;
`endif
                end
            end
`ifdef MUL_SIGNED_EN
            // Two's-complement negation as ~x + 0 + Cin through the shared adder.
            ST_NEG_IN_A: begin
                add_a   = ~m_q;
                add_b   = '0;
                add_cin = 1'b1;
                if (sgn_q && m_q[XLEN-1]) m_d = add_f;
                state_d = ST_NEG_IN_B;
            end
            ST_NEG_IN_B: begin
                add_a   = ~plo_q;
                add_b   = '0;
                add_cin = 1'b1;
                if (sgn_q && plo_q[XLEN-1]) plo_d = add_f;
                state_d = ST_CALC;
            end
`endif
            ST_CALC: begin
                // Adder carry-out becomes the new top bit of Phi after the right shift.
                if (plo_q[0]) begin
                    phi_d = {add_co, add_f[XLEN-1:1]};
                    plo_d = {add_f[0], plo_q[XLEN-1:1]};
                end else begin
                    phi_d = {1'b0, phi_q[XLEN-1:1]};
                    plo_d = {phi_q[0], plo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
`ifdef MUL_SIGNED_EN
                    state_d = ST_NEG_OUT_LO;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef MUL_SIGNED_EN
            ST_NEG_OUT_LO: begin
                add_a   = ~plo_q;
                add_b   = '0;
                add_cin = 1'b1;
                if (neg_q) begin
                    plo_d = add_f;
                    cy_d  = add_co;
                end
                state_d = ST_NEG_OUT_HI;
            end
            ST_NEG_OUT_HI: begin
                add_a   = ~phi_q;
                add_b   = '0;
                add_cin = cy_q;
                if (neg_q) phi_d = add_f;
                state_d = ST_DONE;
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            zf_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef MUL_SIGNED_EN
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            cy_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            cnt_q   <= cnt_d;
            // Product is captured from the final next-state words on DONE entry,
            // so it is stable for the whole done pulse that follows.
            if (state_d == ST_DONE && state_q != ST_DONE) begin
                prod_q <= {phi_d, plo_d};
                zf_q   <= ({phi_d, plo_d} == '0);
            end
            done_q  <= (state_q == ST_DONE);
`ifdef MUL_SIGNED_EN
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            cy_q    <= cy_d;
`endif
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign prod = prod_q;
    assign zf   = zf_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: reset values, latency, busy window, done pulse shape,
// product/zero-flag results, ignored start while busy, and mid-operation reset.
module tb_mul_seq;

`ifdef MUL_SIGNED_EN
    localparam int LAT = 37;
`else
    localparam int LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        sgn;
    logic        busy, done, zf;
    logic [63:0] prod;

    int chk_cnt = 0;
    int err_cnt = 0;

    mul_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .sgn   (sgn),
        .busy  (busy),
        .done  (done),
        .prod  (prod),
        .zf    (zf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Issue one multiply and follow it to the done pulse. prev is the product
    // that must still be held from the previous operation while this one runs.
    task automatic run_op(input string tag, input logic [31:0] opa, input logic [31:0] opb,
                          input logic s, input logic [63:0] exp, input logic [63:0] prev,
                          input bit poke);
        int n;
        int busy_n;
        bit seen;
        @(posedge clk); #1;
        a = opa; b = opb; sgn = s; start = 1'b1;
        @(posedge clk); #1;          // accepting edge
        start = 1'b0;
        check({tag, "_busy_acc"}, {63'd0, busy}, 64'd1);
        busy_n = busy ? 1 : 0;
        n = 0;
        seen = 0;
        while (n < 100 && !seen) begin
            if (poke && n == 4) begin
                a = ~opa; b = ~opb; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (n == 3) check({tag, "_prod_hold"}, prod, prev);
            if (done) seen = 1;
            else if (busy) busy_n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'(LAT));
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(LAT));
        check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_prod"}, prod, exp);
        check({tag, "_zf"}, {63'd0, zf}, {63'd0, (exp == 64'd0)});
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; sgn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_prod", prod, 64'd0);
        check("rst_zf",   {63'd0, zf}, 64'd1);
        rst = 1'b0;

        // Unsigned extremes, with an extra start dropped mid-operation.
        run_op("ff_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 64'd0, 1'b1);
        dones = 0;
        repeat (45) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("ff_ff_extra_done", 64'(dones), 64'd0);

        // Reset in the middle of CALC clears everything immediately.
        @(posedge clk); #1;
        a = 32'h1234; b = 32'h5678; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_prod", prod, 64'd0);
        check("midrst_zf",   {63'd0, zf}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("7x6",     32'd7, 32'd6, 1'b0, 64'h2A, 64'd0, 1'b0);
        run_op("zero",    32'd0, 32'h1234_5678, 1'b0, 64'd0, 64'h2A, 1'b0);
        run_op("1x1",     32'd1, 32'd1, 1'b0, 64'd1, 64'd0, 1'b0);
        run_op("m3x5_u",  32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1, 64'd1, 1'b0);
`ifdef MUL_SIGNED_EN
        run_op("m3x5_s",  32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1,
               64'h0000_0004_FFFF_FFF1, 1'b0);
        run_op("min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000,
               64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        run_op("5xm3_s",  32'd5, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1,
               64'h4000_0000_0000_0000, 1'b0);
        run_op("m3xm3_s", 32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b1, 64'd9,
               64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
`else
        run_op("m3x5_sgn_ign", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'h0000_0004_FFFF_FFF1,
               64'h0000_0004_FFFF_FFF1, 1'b0);
        run_op("min_min_u", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000,
               64'h0000_0004_FFFF_FFF1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
